// File: rtl/palindrome_check_arbiter.sv
// ============================================================================
// palindrome_check_arbiter: round-robin shared bit-serial palindrome checker
// Revision: 1.0
// ============================================================================
`default_nettype none

module palindrome_check_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ*W-1:0]   i_data,
  output logic [N_REQ-1:0]     o_ack,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_is_pal,
  output logic [IDW-1:0]       o_id
);

  localparam int IXW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CMP    = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [W-1:0]     cap_q, cap_d;
  logic [IXW-1:0]   idx_q, idx_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             verdict_q, verdict_d;

  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_cand_id;
  int               w_cand;
  logic [IXW-1:0]   w_hi_idx;
  logic             w_match;
  logic             w_last;

  // Search starts just past the last winner, so that winner has lowest priority.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_cand    = 0;
    w_cand_id = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand    = (int'(rr_ptr_q) + i) % N_REQ;
      w_cand_id = IDW'(w_cand);
      if (!w_gnt_vld && i_req[w_cand_id]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_cand_id;
      end
    end
  end

  assign w_hi_idx = IXW'(W - 1) - idx_q;
  assign w_match  = (cap_q[idx_q] == cap_q[w_hi_idx]);
  assign w_last   = (idx_q == IXW'(W / 2 - 1));

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    cap_d     = cap_q;
    idx_d     = idx_q;
    ack_d     = '0;
    verdict_d = verdict_q;
    case (state_q)
      S_IDLE: begin
        if (w_gnt_vld) begin
          cap_d           = i_data[int'(w_gnt_id)*W +: W];
          rr_ptr_d        = w_gnt_id;
          id_d            = w_gnt_id;
          idx_d           = '0;
          ack_d[w_gnt_id] = 1'b1;
          state_d         = S_CMP;
        end
      end
      S_CMP: begin
        if (!w_match) begin
          verdict_d = 1'b0;
          state_d   = S_RESULT;
        end else if (w_last) begin
          verdict_d = 1'b1;
          state_d   = S_RESULT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RESULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= IDW'(N_REQ - 1);
      id_q      <= '0;
      cap_q     <= '0;
      idx_q     <= '0;
      ack_q     <= '0;
      verdict_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      cap_q     <= cap_d;
      idx_q     <= idx_d;
      ack_q     <= ack_d;
      verdict_q <= verdict_d;
    end
  end

  assign o_ack    = ack_q;
  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_RESULT);
  assign o_is_pal = o_done & verdict_q;
  assign o_id     = id_q;

endmodule

`default_nettype wire

// File: tb/tb_palindrome_check_arbiter.sv
// ============================================================================
// tb_palindrome_check_arbiter: directed and randomized checks against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_palindrome_check_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   data = '0;
  logic [N-1:0]     ack;
  logic             busy, done, is_pal;
  logic [IDW-1:0]   id;

  int errors = 0;
  int checks = 0;
  int model_ptr = N - 1;
  logic [W-1:0] words [N];

  palindrome_check_arbiter #(.N_REQ(N), .W(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
    .o_ack(ack), .o_busy(busy), .o_done(done), .o_is_pal(is_pal), .o_id(id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference verdict: first mismatching outer/inner pair decides, else palindrome.
  function automatic void pal_model(input logic [W-1:0] w, output bit pal, output int k);
    bit found;
    found = 0;
    pal   = 1;
    k     = W / 2;
    for (int i = 0; i < W / 2; i++) begin
      if (!found && (w[i] != w[W-1-i])) begin
        found = 1;
        pal   = 0;
        k     = i + 1;
      end
    end
  endfunction

  function automatic int rr_next(input int ptr, input logic [N-1:0] r);
    int c;
    for (int i = 1; i <= N; i++) begin
      c = (ptr + i) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = W'($urandom);
    if ($urandom_range(0, 1) == 1)
      for (int i = 0; i < W / 2; i++) w[W-1-i] = w[i];
    return w;
  endfunction

  task automatic set_word(input int k, input logic [W-1:0] w);
    words[k] = w;
    data[k*W +: W] = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_ptr = N - 1;
  endtask

  // Runs one grant-to-result transaction from an IDLE cycle and checks timing and verdict.
  task automatic serve(input string name, input int exp_id, input int exp_wait,
                       input bit drop_req, input bit refresh);
    bit pal;
    int k, n, m;
    logic [W-1:0] w;
    logic [N-1:0] exp_ack;
    w = words[exp_id];
    pal_model(w, pal, k);
    exp_ack = '0;
    exp_ack[exp_id] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ack == '0 && n < 20);
    checks++;
    if (ack !== exp_ack || n != exp_wait || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s ack: got ack=%b wait=%0d busy=%b, want ack=%b wait=%0d busy=1",
               name, ack, n, busy, exp_ack, exp_wait);
    end
    model_ptr = exp_id;
    if (drop_req) req[exp_id] = 1'b0;
    if (refresh) set_word(exp_id, rand_word());
    m = 0;
    do begin
      tick();
      m++;
      if (!done) begin
        checks++;
        if (busy !== 1'b1 || ack !== '0 || is_pal !== 1'b0) begin
          errors++;
          $display("FAIL %s cmp: got busy=%b ack=%b is_pal=%b, want busy=1 ack=0 is_pal=0",
                   name, busy, ack, is_pal);
        end
      end
    end while (!done && m < 40);
    checks++;
    if (done !== 1'b1 || m != k || is_pal !== pal || id !== IDW'(exp_id)) begin
      errors++;
      $display("FAIL %s result: got done=%b lat=%0d pal=%b id=%0d, want done=1 lat=%0d pal=%b id=%0d",
               name, done, m, is_pal, id, k, pal, exp_id);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || is_pal !== 1'b0 || id !== IDW'(exp_id)) begin
      errors++;
      $display("FAIL %s idle: got busy=%b done=%b pal=%b id=%0d, want 0 0 0 id=%0d",
               name, busy, done, is_pal, id, exp_id);
    end
  endtask

  task automatic test_reset();
    req = '1;
    for (int i = 0; i < N; i++) set_word(i, rand_word());
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ack !== '0 || busy !== 1'b0 || done !== 1'b0 || is_pal !== 1'b0 || id !== '0) begin
        errors++;
        $display("FAIL reset: got ack=%b busy=%b done=%b pal=%b id=%0d, want all 0",
                 ack, busy, done, is_pal, id);
      end
    end
    rst_n = 1'b1;
    model_ptr = N - 1;
    serve("reset_first_grant", 0, 1, 1, 0);
    req = '0;
  endtask

  task automatic test_directed();
    set_word(1, 8'b1001_1001);
    req[1] = 1'b1;
    serve("pal_full", 1, 1, 1, 0);
    set_word(2, 8'b1000_0000);
    req[2] = 1'b1;
    serve("early_mismatch", 2, 1, 1, 0);
    set_word(0, 8'b1010_0101);
    req[0] = 1'b1;
    serve("late_match", 0, 1, 1, 0);
    set_word(0, 8'b1011_0101);
    req[0] = 1'b1;
    serve("late_mismatch", 0, 1, 1, 0);
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, rand_word());
    req = '1;
    for (int r = 0; r < 2 * N + 1; r++) begin
      g = rr_next(model_ptr, req);
      checks++;
      if (g != r % N) begin
        errors++;
        $display("FAIL rr_order: model picked %0d, want %0d", g, r % N);
      end
      serve("round_robin", g, 1, 0, 1);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_cmp();
    logic [N-1:0] exp_ack;
    do_reset();
    set_word(2, 8'b1001_1001);
    req = 4'b0100;
    tick();
    exp_ack = 4'b0100;
    checks++;
    if (ack !== exp_ack) begin
      errors++;
      $display("FAIL midrst_ack: got %b, want %b", ack, exp_ack);
    end
    req[2] = 1'b0;
    set_word(1, rand_word());
    set_word(3, rand_word());
    req[1] = 1'b1;
    req[3] = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== '0 || busy !== 1'b0 || done !== 1'b0 || is_pal !== 1'b0 || id !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got ack=%b busy=%b done=%b pal=%b id=%0d, want all 0",
               ack, busy, done, is_pal, id);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold: got done=%b busy=%b, want 0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    model_ptr = N - 1;
    serve("midrst_after_1", rr_next(model_ptr, req), 1, 1, 0);
    serve("midrst_after_3", rr_next(model_ptr, req), 1, 1, 0);
  endtask

  task automatic test_back_to_back_random();
    int g;
    logic [N-1:0] add;
    for (int it = 0; it < 40; it++) begin
      if (req == '0) add = N'($urandom_range(1, (1 << N) - 1));
      else           add = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (add[i] && !req[i]) begin
          set_word(i, rand_word());
          req[i] = 1'b1;
        end
      end
      g = rr_next(model_ptr, req);
      serve("random", g, 1, 1, 0);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_reset_mid_cmp();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
